// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among four byte sources. A round-robin search
// picks a requester while idle. Its byte is launched with a one-clock
// tx_enable strobe. The arbiter then waits for the transmitter to raise
// tx_busy and waits again for it to drop. It inserts GUARD_CYCLES idle clocks
// before the next frame. If tx_busy does not rise within BUSY_TIMEOUT clocks,
// the byte is dropped and timeout_err pulses for one clock.
//
// Parameters
//   GUARD_CYCLES  idle clocks between consecutive frames (0 allowed)
//   BUSY_TIMEOUT  clocks to wait for tx_busy after launch (>= 2)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   req_valid    per-requester byte-available flags
//   req_data     packed bytes, requester i at [8i+7:8i]
//   req_ready    accept strobe, one-hot or zero, only while idle
//   tx_enable    one-clock start strobe to the transmitter
//   tx_data      byte held for the transmitter for the whole frame
//   tx_busy      transmitter busy flag
//   grant_id     requester owning the current frame
//   active       high whenever the arbiter is not idle
//   timeout_err  one-clock pulse when tx_busy failed to rise in time
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int GUARD_CYCLES = 2,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ready,
   output logic        tx_enable,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   output logic [1:0]  grant_id,
   output logic        active,
   output logic        timeout_err
);

   // One counter serves both the busy wait and the guard gap. It is sized
   // for the larger of the two limits, so it never wraps inside a state.
   localparam int CNT_MAX = (GUARD_CYCLES > BUSY_TIMEOUT) ? GUARD_CYCLES : BUSY_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE,
      GUARD
   } state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_next;
   logic [1:0]      last_grant;
   logic [1:0]      winner;
   logic            accept;
   logic            timeout_next;

   // Round-robin pick. The loop walks the search order backwards, so the
   // last match kept is the requester nearest to last_grant + 1.
   always_comb begin
      winner = last_grant + 2'd1;
      for (int k = 3; k >= 0; k--) begin
         if (req_valid[last_grant + 2'd1 + 2'(k)]) winner = last_grant + 2'd1 + 2'(k);
      end
   end

   // Reset forces req_ready low even while requesters hold valid.
   assign accept = (state == IDLE) && (|req_valid) && !rst;
   assign active = (state != IDLE);

   always_comb begin
      // NOTE: every output gets a default before the case, so no path leaves
      // one unassigned and no latch is inferred.
      state_next   = state;
      cnt_next     = cnt;
      timeout_next = 1'b0;
      req_ready    = '0;
      tx_enable    = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               req_ready[winner] = 1'b1;
               state_next        = LAUNCH;
            end
         end
         LAUNCH: begin
            tx_enable  = 1'b1;
            cnt_next   = '0;
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // Busy already high on the first clock here exits at once.
            if (tx_busy) begin
               state_next = WAIT_DONE;
            end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
               timeout_next = 1'b1;
               state_next   = IDLE;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               cnt_next   = '0;
               state_next = (GUARD_CYCLES > 0) ? GUARD : IDLE;
            end
         end
         GUARD: begin
            if (cnt == CW'(GUARD_CYCLES - 1)) state_next = IDLE;
            else                              cnt_next   = cnt + CW'(1);
         end
         default: state_next = IDLE;
      endcase
   end

   // last_grant resets to 3 so that the first search starts at requester 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         timeout_err <= 1'b0;
         tx_data     <= 8'h00;
         grant_id    <= 2'd0;
         last_grant  <= 2'd3;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register updates from the values present before the edge.
         state       <= state_next;
         cnt         <= cnt_next;
         timeout_err <= timeout_next;
         if (accept) begin
            tx_data    <= req_data[{winner, 3'b000} +: 8];
            grant_id   <= winner;
            last_grant <= winner;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Drives two instances. The main one is built with GUARD_CYCLES=2 and
// BUSY_TIMEOUT=4. A second one is built with GUARD_CYCLES=0. The main
// instance is tracked every cycle by a timestamp model of the frame rules.
// Directed scenarios add literal expectations that pin that model.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int G   = 2;
   localparam int B   = 4;
   localparam int BIG = 32'h7fff_ffff;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data  = '0;
   logic        tx_busy   = 1'b0;
   logic [3:0]  req_ready;
   logic        tx_enable;
   logic [7:0]  tx_data;
   logic [1:0]  grant_id;
   logic        active;
   logic        timeout_err;

   logic [3:0]  v0 = '0;
   logic [31:0] d0 = '0;
   logic        busy0 = 1'b0;
   logic [3:0]  ready0;
   logic        ten0;
   logic [7:0]  txd0;
   logic [1:0]  gid0;
   logic        act0;
   logic        to0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.GUARD_CYCLES(G), .BUSY_TIMEOUT(B)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_enable(tx_enable), .tx_data(tx_data),
      .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
      .timeout_err(timeout_err));

   uart_tx_arbiter #(.GUARD_CYCLES(0), .BUSY_TIMEOUT(B)) dut_g0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_data(d0),
      .req_ready(ready0), .tx_enable(ten0), .tx_data(txd0),
      .tx_busy(busy0), .grant_id(gid0), .active(act0),
      .timeout_err(to0));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] v);
      for (int k = 1; k <= 4; k++) begin
         if (v[(int'(last) + k) % 4]) return 2'((int'(last) + k) % 4);
      end
      return 2'd0;
   endfunction

   // ---------------- timestamp model of the main instance ------------------
   int         cyc    = 0;
   bit         m_in   = 1'b0;
   int         m_acc  = 0;
   int         m_rise = -1;
   int         m_idle = BIG;
   int         m_to   = -1;
   logic [1:0] m_last = 2'd3;
   logic [1:0] m_gid  = 2'd0;
   logic [7:0] m_data = 8'h00;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_in = 1'b0; m_last = 2'd3; m_gid = 2'd0; m_data = 8'h00;
            m_to = -1; cyc = 0;
         end else begin
            if (!m_in) begin
               if (req_valid != 4'b0) begin
                  m_gid  = rr_pick(m_last, req_valid);
                  m_last = m_gid;
                  m_data = req_data[8*m_gid +: 8];
                  m_in   = 1'b1;
                  m_acc  = cyc;
                  m_rise = -1;
                  m_idle = BIG;
               end
            end else begin
               if (m_rise < 0) begin
                  if (cyc >= m_acc + 2) begin
                     if (tx_busy)                 m_rise = cyc;
                     else if (cyc == m_acc + 1 + B) begin
                        m_to = cyc + 1; m_idle = cyc + 1;
                     end
                  end
               end else if (m_idle == BIG && cyc > m_rise && !tx_busy) begin
                  m_idle = cyc + 1 + G;
               end
               if (cyc + 1 == m_idle) m_in = 1'b0;
            end
            cyc++;
         end
      end
   end

   // ---------------- per-cycle compare -------------------------------------
   bit         cmp_on    = 1'b1;
   bit         prev_act  = 1'b0;
   logic [7:0] prev_data = 8'h00;

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_on) begin
            check("req_ready", req_ready,
                  (rst || m_in || req_valid == 4'b0) ? 4'b0 : (4'b1 << rr_pick(m_last, req_valid)));
            check("tx_enable", tx_enable, m_in && cyc == m_acc + 1);
            check("tx_data", tx_data, m_data);
            check("grant_id", grant_id, m_gid);
            check("active", active, m_in);
            check("timeout_err", timeout_err, cyc == m_to);
            if (prev_act && active) check("tx_data_stable", tx_data, prev_data);
            prev_act  = active;
            prev_data = tx_data;
         end
      end
   end

   // ---------------- requesters, transmitter, sampling ---------------------
   int         rq_left [4] = '{0, 0, 0, 0};
   logic [7:0] rq_byte [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
   bit         uart_auto = 1'b1;
   int         u_left = 0;
   logic [3:0] s_ready, s0_ready;
   logic       s_ten, s_act, s_to, s_busy, s0_ten, s0_act;
   logic [7:0] s_txd, s0_txd;
   logic [1:0] s_gid;

   task automatic drive_reqs();
      for (int i = 0; i < 4; i++) begin
         req_valid[i]        = (rq_left[i] > 0);
         req_data[8*i +: 8]  = rq_byte[i];
      end
   endtask

   task automatic offer(input int i, input int n, input logic [7:0] b);
      rq_left[i] = n;
      rq_byte[i] = b;
      drive_reqs();
   endtask

   // One clock: sample outputs at the falling edge, then update inputs just
   // after the next rising edge. A requester drops a byte once it is accepted.
   // The automatic transmitter raises busy the clock after tx_enable and
   // holds it for three clocks.
   task automatic step();
      logic [3:0] got;
      @(negedge clk);
      s_ready = req_ready; s_ten = tx_enable; s_txd = tx_data; s_gid = grant_id;
      s_act = active; s_to = timeout_err; s_busy = tx_busy;
      s0_ready = ready0; s0_ten = ten0; s0_txd = txd0; s0_act = act0;
      got = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (got[i]) begin
            rq_left[i]--;
            rq_byte[i] = rq_byte[i] + 8'h40;
         end
      end
      drive_reqs();
      if (rst) begin
         if (uart_auto) tx_busy = 1'b0;
         u_left = 0;
      end else if (uart_auto) begin
         if (s_ten) begin
            tx_busy = 1'b1; u_left = 3;
         end else if (u_left > 0) begin
            u_left--;
            if (u_left == 0) tx_busy = 1'b0;
         end
      end
   endtask

   function automatic bit cond(input int which);
      case (which)
         0:       return s_ready != 4'b0;
         1:       return s_ten;
         2:       return s_busy;
         3:       return !s_busy;
         4:       return !s_act;
         default: return s_to;
      endcase
   endfunction

   task automatic wait_for(input string name, input int which, input int budget);
      bit ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         step();
         ok = cond(which);
      end
      if (!ok) check(name, 32'd0, 32'd1);
   endtask

   function automatic int idx_of(input logic [3:0] oh);
      for (int i = 0; i < 4; i++) if (oh[i]) return i;
      return -1;
   endfunction

   // ---------------- directed scenarios ------------------------------------
   int         n;
   int         gq[$];
   logic [7:0] bq[$];
   int         exp_g[5] = '{0, 1, 2, 3, 0};
   logic [7:0] exp_b[5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h50};

   initial begin
      repeat (2) step();
      check("rst_tx_data", s_txd, 8'h00);
      check("rst_grant", s_gid, 2'd0);
      check("rst_active", s_act, 1'b0);
      check("rst_ready", s_ready, 4'b0);
      rst = 1'b0;

      // Single request from requester 2.
      offer(2, 1, 8'hA5);
      wait_for("t1_wait_ready", 0, 20);
      check("t1_ready", s_ready, 4'b0100);
      step();
      check("t1_launch", s_ten, 1'b1);
      check("t1_tx_data", s_txd, 8'hA5);
      check("t1_grant", s_gid, 2'd2);
      n = 1;
      for (int k = 0; k < 30; k++) begin
         step();
         if (!s_act) break;
         n++;
      end
      check("t1_frame_len", n, 7);

      // Reset while waiting for busy to fall; requester 1 wins after 2.
      offer(1, 1, 8'h77);
      wait_for("t2_wait_busy", 2, 20);
      check("t2_pre_active", active, 1'b1);
      rst = 1'b1;
      #1;
      check("t2_rst_active", active, 1'b0);
      check("t2_rst_tx_data", tx_data, 8'h00);
      check("t2_rst_grant", grant_id, 2'd0);
      check("t2_rst_tx_enable", tx_enable, 1'b0);
      check("t2_rst_ready", req_ready, 4'b0);
      step();
      rst = 1'b0;

      // All four requesters valid: order 0,1,2,3,0.
      offer(0, 2, 8'h10); offer(1, 1, 8'h21); offer(2, 1, 8'h32); offer(3, 1, 8'h43);
      for (int k = 0; k < 300; k++) begin
         step();
         if (s_ready != 4'b0) gq.push_back(idx_of(s_ready));
         if (s_ten) bq.push_back(s_txd);
         if (gq.size() >= 5 && bq.size() >= 5 && !s_act) break;
      end
      check("t3_grant_count", gq.size(), 5);
      check("t3_byte_count", bq.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < gq.size()) check($sformatf("t3_grant_%0d", i), gq[i], exp_g[i]);
         if (i < bq.size()) check($sformatf("t3_byte_%0d", i), bq[i], exp_b[i]);
      end

      // Transmitter never answers: timeout, then the next requester.
      uart_auto = 1'b0;
      offer(2, 1, 8'hC3); offer(3, 1, 8'h3C);
      wait_for("t4_wait_launch", 1, 20);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         n++;
         if (s_to) break;
      end
      check("t4_timeout_delay", n, B + 1);
      check("t4_next_ready", s_ready, 4'b1000);
      check("t4_idle_on_pulse", s_act, 1'b0);
      wait_for("t4_wait_second_to", 5, 20);
      uart_auto = 1'b1;

      // Request raised during the guard gap waits for idle.
      offer(1, 1, 8'h66);
      wait_for("t5_wait_busy", 2, 20);
      wait_for("t5_wait_fall", 3, 20);
      offer(3, 1, 8'h99);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (s_ready != 4'b0) break;
         n++;
      end
      check("t5_guard_hold", n, G);
      check("t5_ready", s_ready, 4'b1000);
      wait_for("t5_wait_launch", 1, 20);
      wait_for("t5_wait_idle", 4, 30);

      // Busy already high while idle does not block acceptance.
      uart_auto = 1'b0;
      tx_busy   = 1'b1;
      offer(0, 1, 8'hE1);
      step();
      check("t6_ready", s_ready, 4'b0001);
      step();
      check("t6_launch", s_ten, 1'b1);
      step();
      tx_busy = 1'b0;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (!s_act) break;
         n++;
      end
      check("t6_tail_len", n, 1 + G);
      uart_auto = 1'b1;

      // Zero-guard instance returns to idle the clock after busy falls.
      v0 = 4'b0001; d0 = 32'h0000_005A;
      step();
      check("g0_ready", s0_ready, 4'b0001);
      v0 = 4'b0; d0 = '0; busy0 = 1'b1;
      step();
      check("g0_launch", s0_ten, 1'b1);
      check("g0_data_launch", s0_txd, 8'h5A);
      step();
      check("g0_data_wait", s0_txd, 8'h5A);
      step();
      check("g0_data_busy", s0_txd, 8'h5A);
      busy0 = 1'b0;
      step();
      check("g0_active_fall", s0_act, 1'b1);
      check("g0_data_fall", s0_txd, 8'h5A);
      step();
      check("g0_idle", s0_act, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got running, expected finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 2, giving the idle clocks inserted between consecutive frames (0 allowed).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 4, giving the max clocks after launch to wait for tx_busy rising (>=2).
REQ-003 SHALL have port clk, input, 1, system clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 4, per-requester byte-available flag.
REQ-006 SHALL have port req_data, input, 32, packed bytes: requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_ready, output, 4, per-requester accept strobe (one-hot or zero).
REQ-008 SHALL have port tx_enable, output, 1, start request to the UART transmitter.
REQ-009 SHALL have port tx_data, output, 8, byte presented to the transmitter data input.
REQ-010 SHALL have port tx_busy, input, 1, transmitter busy flag.
REQ-011 SHALL have port grant_id, output, 2, index of requester owning the current frame.
REQ-012 SHALL have port active, output, 1, high in every state except IDLE.
REQ-013 SHALL have port timeout_err, output, 1, one-clock pulse on busy-timeout.

Function
REQ-014 SHALL implement states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GUARD.
REQ-015 IDLE: if any req_valid, SHALL pick the winner round-robin, assert req_ready[winner] combinationally in that clock, latch req_data byte into tx_data, latch grant_id, go to LAUNCH; else stay.
REQ-016 Round-robin: search order starts at (last_grant+1) mod 4; after reset the search starts at requester 0.
REQ-017 A transfer SHALL occur only when req_valid[i] and req_ready[i] are both high; requesters hold valid/data until ready.
REQ-018 req_ready SHALL be zero in all states except IDLE and never have more than one bit set.
REQ-019 LAUNCH: tx_enable SHALL be 1 for exactly this one clock; next state WAIT_BUSY with wait counter cleared.
REQ-020 WAIT_BUSY: on tx_busy=1 go to WAIT_DONE; else increment counter; when counter reaches BUSY_TIMEOUT pulse timeout_err, go to IDLE (byte dropped, last_grant still updated).
REQ-021 WAIT_DONE: on tx_busy=0 go to GUARD if GUARD_CYCLES>0, else IDLE.
REQ-022 GUARD: stay exactly GUARD_CYCLES clocks, then IDLE; requests arriving during GUARD are not accepted until IDLE.
REQ-023 tx_data SHALL remain constant from LAUNCH through the exit of WAIT_DONE (transmitter samples data bits during transmission).
REQ-024 tx_enable SHALL be 0 in every state except LAUNCH.
REQ-025 Minimum frame-to-frame ready spacing = 1 (IDLE) + 1 (LAUNCH) + busy-wait + busy duration + GUARD_CYCLES clocks.
REQ-026 tx_busy already high in IDLE SHALL NOT block acceptance; WAIT_BUSY exits immediately if tx_busy=1 on its first clock.
REQ-027 Guard/timeout counters SHALL be wide enough for the parameter values and never wrap inside a state.

Reset
REQ-028 On rst: state IDLE, tx_enable 0, tx_data 8'h00, grant_id 0, last_grant 3 (so requester 0 first), counters 0, timeout_err 0, active 0, req_ready 0.
REQ-029 rst asserted mid-frame SHALL abort immediately; the in-flight byte is lost and no ready is reissued for it.
REQ-030 First request evaluation SHALL occur on the first rising clk edge after rst deasserts.

Verification
REQ-031 Single request: req_valid=4'b0100, data 8'hA5 -> req_ready=4'b0100 one clock, tx_enable one clock later, tx_data=8'hA5, grant_id=2, frame completes.
REQ-032 All four valid continuously -> grants in order 0,1,2,3,0; each byte appears on tx_data once; GUARD_CYCLES=2 idle clocks between busy fall and next ready.
REQ-033 tx_busy held 0 after launch -> timeout_err pulse exactly BUSY_TIMEOUT clocks after WAIT_BUSY entry, return to IDLE, next requester served.
REQ-034 rst pulsed during WAIT_DONE -> all outputs at reset values same cycle (async); next grant goes to requester 0.
REQ-035 req_valid asserted only during GUARD -> req_ready stays 0 until IDLE, then asserted on first IDLE clock.
REQ-036 GUARD_CYCLES=0 build -> IDLE entered the clock after tx_busy falls; tx_data stable throughout each frame checked by assertion.
